// File: rtl/counter_scheduler_pkg.sv
// Shared definitions for the counter scheduler and its round-robin picker.
// Holds the state encodings and the default counter and requester sizes.
package counter_scheduler_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/counter_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from ptr.
// Reusable by any block that arbitrates a shared resource.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down so the closest hit to ptr is written last.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
         if (req_i[cand]) begin
            idx_o   = cand;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one up-counter among N_REQ requesters.
// Grants one run at a time, counts 1..len, then pulses done to the owner.
module counter_scheduler
   import counter_scheduler_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] len,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [WIDTH-1:0]       count,
   output logic                   is_one
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] w_q, w_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic [WIDTH-1:0] len_sel;
   logic [N_REQ-1:0] owner_oh;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_vld)
   );

   assign len_sel = len[pick_idx*WIDTH +: WIDTH];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      w_d     = w_q;
      len_d   = len_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               w_d   = pick_idx;
               len_d = len_sel;
               ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
               if (len_sel != '0) begin
                  state_d = S_RUN;
                  count_d = WIDTH'(1);
               end else begin
                  state_d = S_DONE;
                  count_d = '0;
               end
            end
         end
         S_RUN: begin
            // Abort outranks completion, so a dropped req never sees done.
            if (!req[w_q]) begin
               state_d = S_IDLE;
               count_d = '0;
            end else if (count_q == len_q) begin
               state_d = S_DONE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         w_q     <= '0;
         len_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         w_q     <= w_d;
         len_q   <= len_d;
         count_q <= count_d;
      end
   end

   assign owner_oh = N_REQ'(1) << w_q;
   assign grant    = (state_q == S_RUN)  ? owner_oh : '0;
   assign done     = (state_q == S_DONE) ? owner_oh : '0;
   assign busy     = (state_q == S_RUN) || (state_q == S_DONE);
   assign count    = count_q;
   assign is_one   = (state_q == S_RUN) && (count_q == WIDTH'(1));

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed and randomized bench for counter_scheduler against a job-timeline model.
// The model tracks each job as (owner, length, cycles elapsed since grant).
module tb_counter_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] len;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           busy;
   logic [W-1:0]   count;
   logic           is_one;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: a job occupies cycles 1..L counting, cycle L+1 is its done cycle.
   int m_owner = -1;
   int m_len   = 0;
   int m_el    = 0;
   int m_ptr   = 0;
   int m_count = 0;

   int cyc = 0;
   int gcyc = 0;
   int dcyc = 0;
   int max_count = 0;
   int d_cnt [N];
   int g_q[$];
   int gc_q[$];
   logic [N-1:0] prev_grant = '0;

   counter_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .len    (len),
      .grant  (grant),
      .done   (done),
      .busy   (busy),
      .count  (count),
      .is_one (is_one)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] oh(int i);
      return N'(1) << i;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_len(int i, int v);
      len[i*W +: W] = W'(v);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_len   = 0;
      m_el    = 0;
      m_ptr   = 0;
      m_count = 0;
   endtask

   task automatic model_edge();
      if (m_owner < 0) begin
         if (req != '0) begin
            for (int k = 0; k < N; k++) begin
               if (req[(m_ptr + k) % N]) begin
                  m_owner = (m_ptr + k) % N;
                  break;
               end
            end
            m_len   = int'(len[m_owner*W +: W]);
            m_el    = 1;
            m_ptr   = (m_owner + 1) % N;
            m_count = (m_len > 0) ? 1 : 0;
         end
      end else if (m_el <= m_len) begin
         if (!req[m_owner]) begin
            m_owner = -1;
            m_count = 0;
         end else begin
            m_el++;
            if (m_el <= m_len) m_count = m_el;
         end
      end else begin
         m_owner = -1;
      end
   endtask

   task automatic check_all();
      logic run, dn;
      run = (m_owner >= 0) && (m_el <= m_len);
      dn  = (m_owner >= 0) && (m_el == m_len + 1);
      chk("grant",  32'(grant),  run ? 32'(oh(m_owner)) : 32'd0);
      chk("done",   32'(done),   dn  ? 32'(oh(m_owner)) : 32'd0);
      chk("busy",   32'(busy),   32'(m_owner >= 0));
      chk("count",  32'(count),  32'(m_count));
      chk("is_one", 32'(is_one), 32'(run && (m_count == 1)));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_all();
      if (grant != '0) gcyc++;
      if (done != '0) dcyc++;
      if (int'(count) > max_count) max_count = int'(count);
      for (int i = 0; i < N; i++) if (done[i]) d_cnt[i]++;
      if (prev_grant == '0 && grant != '0) begin
         for (int i = 0; i < N; i++) if (grant[i]) g_q.push_back(i);
         gc_q.push_back(cyc);
      end
      prev_grant = grant;
      if ((m_owner >= 0) && (m_el == m_len + 1)) req[m_owner] = 1'b0;
   endtask

   task automatic clear_stats();
      gcyc = 0;
      dcyc = 0;
      max_count = 0;
      g_q.delete();
      gc_q.delete();
      for (int i = 0; i < N; i++) d_cnt[i] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      #1;
      model_reset();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_count", 32'(count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      prev_grant = '0;
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      len   = '0;
      #3;
      chk("por_grant",  32'(grant),  32'd0);
      chk("por_done",   32'(done),   32'd0);
      chk("por_busy",   32'(busy),   32'd0);
      chk("por_count",  32'(count),  32'd0);
      chk("por_is_one", 32'(is_one), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Single request, length 3.
      clear_stats();
      set_len(0, 3);
      req[0] = 1'b1;
      repeat (6) tick();
      chk("single_gcyc", 32'(gcyc), 32'd3);
      chk("single_dcyc", 32'(d_cnt[0]), 32'd1);

      // All four at once, length 2 each, ptr back at 0.
      do_reset();
      clear_stats();
      for (int i = 0; i < N; i++) set_len(i, 2);
      req = '1;
      repeat (18) tick();
      chk("all_njobs", 32'(g_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < g_q.size(); i++) begin
         chk("all_order", 32'(g_q[i]), 32'(i));
         chk("all_done", 32'(d_cnt[i]), 32'd1);
         if (i > 0) chk("all_spacing", 32'(gc_q[i] - gc_q[i-1]), 32'd4);
      end

      // Fairness: 1 served, 0 and 2 pending, 1 re-raises behind them.
      do_reset();
      clear_stats();
      set_len(0, 1);
      set_len(1, 2);
      set_len(2, 1);
      req = 4'b0010;
      tick();
      req[0] = 1'b1;
      req[2] = 1'b1;
      tick();
      tick();
      req[1] = 1'b1;
      repeat (16) tick();
      chk("fair_njobs", 32'(g_q.size()), 32'd4);
      if (g_q.size() >= 4) begin
         chk("fair_1st", 32'(g_q[0]), 32'd1);
         chk("fair_2nd", 32'(g_q[1]), 32'd2);
         chk("fair_3rd", 32'(g_q[2]), 32'd0);
         chk("fair_4th", 32'(g_q[3]), 32'd1);
      end

      // Zero length on requester 3.
      clear_stats();
      set_len(3, 0);
      req = 4'b1000;
      tick();
      chk("zero_done",  32'(done),  32'h8);
      chk("zero_count", 32'(count), 32'd0);
      repeat (3) tick();
      chk("zero_gcyc", 32'(gcyc), 32'd0);

      // Abort requester 1 at count 2 of 5, requester 2 pending.
      do_reset();
      clear_stats();
      set_len(1, 5);
      set_len(2, 3);
      req = 4'b0010;
      tick();
      tick();
      chk("abort_pre", 32'(count), 32'd2);
      req[2] = 1'b1;
      req[1] = 1'b0;
      tick();
      chk("abort_count", 32'(count), 32'd0);
      chk("abort_busy",  32'(busy),  32'd0);
      tick();
      chk("abort_next", 32'(grant), 32'h4);
      repeat (6) tick();
      chk("abort_nodone", 32'(d_cnt[1]), 32'd0);
      chk("abort_r2done", 32'(d_cnt[2]), 32'd1);

      // Async reset mid-run, then a 255-long run.
      clear_stats();
      set_len(1, 10);
      req = 4'b0010;
      repeat (3) tick();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("arst_grant",  32'(grant),  32'd0);
      chk("arst_busy",   32'(busy),   32'd0);
      chk("arst_count",  32'(count),  32'd0);
      chk("arst_is_one", 32'(is_one), 32'd0);
      req = '0;
      @(negedge clk);
      reset = 1'b0;
      prev_grant = '0;
      clear_stats();
      set_len(0, 255);
      set_len(1, 1);
      req = 4'b0011;
      repeat (262) tick();
      chk("max_first", 32'(g_q.size() > 0 ? g_q[0] : -1), 32'd0);
      chk("max_count", 32'(max_count), 32'd255);
      chk("max_done",  32'(d_cnt[0]), 32'd1);

      // Randomized traffic with occasional aborts and len churn.
      clear_stats();
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && ($urandom_range(0, 3) == 0)) begin
               set_len(i, ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 7));
               req[i] = 1'b1;
            end else if (i != m_owner && $urandom_range(0, 7) == 0) begin
               set_len(i, $urandom_range(0, 7));
            end
         end
         if (m_owner >= 0 && m_el <= m_len && $urandom_range(0, 39) == 0)
            req[m_owner] = 1'b0;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
